// File: rtl/vsim_pkg.sv
// ---------------------------------------------------------------------------
// vsim_pkg
// Shared definitions for the simulation message path. The serializer uses
// them to build the header beat, and the receive-side decoder uses the same
// constants and helper to take it apart.
//   vsim_state_e      : serializer state (IDLE / HDR / BODY)
//   HDR_ID_SHIFT      : bit position of the method id in the header word
//   HDR_LEN_MASK      : mask for the word-count field of the header
//   vsim_make_header  : packs {id, nwords} into one 32-bit header word
// ---------------------------------------------------------------------------
package vsim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } vsim_state_e;

    localparam int          HDR_ID_SHIFT = 16;
    localparam logic [15:0] HDR_LEN_MASK = 16'hffff;

    // nwords counts every beat of the message, header included.
    function automatic logic [31:0] vsim_make_header(input logic [15:0] id,
                                                     input logic [15:0] nwords);
        return (32'(id) << HDR_ID_SHIFT) | 32'(nwords & HDR_LEN_MASK);
    endfunction

endpackage

// File: rtl/vsim_msg_serializer.sv
// ---------------------------------------------------------------------------
// vsim_msg_serializer
// Takes one whole indication message per handshake (method id plus up to
// MAX_WORDS payload words) and streams it out as width-bit beats: a header
// beat {id, word count incl. header}, then the payload words, with beat_last
// marking the final beat. Feeds the DPI send stage.
//
// Ports:
//   CLK        in   clock, everything on the rising edge
//   nRST       in   synchronous reset, active high
//   EN_msg     in   enqueue strobe, honoured only while RDY_msg is high
//   RDY_msg    out  a message can be accepted this cycle (combinational)
//   msg_id     in   16-bit method number
//   msg_len    in   payload word count (values above MAX_WORDS are clamped)
//   msg_data   in   payload, word k at msg_data[k*width +: width]
//   RDY_beat   out  beat_v / beat_last are valid
//   EN_beat    in   downstream takes the current beat, honoured only with RDY_beat
//   beat_v     out  beat data
//   beat_last  out  final beat of the message
// ---------------------------------------------------------------------------
module vsim_msg_serializer
    import vsim_pkg::*;
#(
    parameter int width     = 32,
    parameter int MAX_WORDS = 4,
    parameter int LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       EN_msg,
    output logic                       RDY_msg,
    input  logic [15:0]                msg_id,
    input  logic [LEN_W-1:0]           msg_len,
    input  logic [MAX_WORDS*width-1:0] msg_data,
    output logic                       RDY_beat,
    input  logic                       EN_beat,
    output logic [width-1:0]           beat_v,
    output logic                       beat_last
);

    localparam int DATA_W = MAX_WORDS * width;
    localparam int SEL_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CMP_W  = LEN_W + 1;

    vsim_state_e          state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic                 rdyBeat_q, rdyBeat_d;
    logic [width-1:0]     beatV_q, beatV_d;
    logic                 beatLast_q, beatLast_d;

    logic                 consume;
    logic                 fin;
    logic                 accept;
    logic [LEN_W-1:0]     lenClamped;
    logic [15:0]          hdrWords;
    logic [LEN_W-1:0]     cntNext;
    logic [SEL_W-1:0]     selBase;
    logic                 bodyLast;

    // Handshake terms. Accepting in the same cycle the final beat leaves is
    // what gives back-to-back messages a zero-bubble beat stream.
    assign consume  = rdyBeat_q && EN_beat;
    assign fin      = consume && beatLast_q;
    assign RDY_msg  = !nRST && ((state_q == IDLE) || fin);
    assign accept   = EN_msg && RDY_msg;

    // The id only appears in the header, so it is folded into beat_v at
    // accept time instead of being kept in the buffer.
    assign lenClamped = (msg_len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : msg_len;
    assign hdrWords   = 16'(lenClamped) + 16'd1;

    // Next payload word for BODY: only used while the current beat is not
    // the last one, so cntNext stays below MAX_WORDS.
    assign cntNext  = cnt_q + LEN_W'(1);
    assign selBase  = SEL_W'(cntNext) * SEL_W'(width);
    assign bodyLast = (CMP_W'(cnt_q) + CMP_W'(2)) == CMP_W'(len_q);

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q    <= IDLE;
            len_q      <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            rdyBeat_q  <= 1'b0;
            beatV_q    <= '0;
            beatLast_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            rdyBeat_q  <= rdyBeat_d;
            beatV_q    <= beatV_d;
            beatLast_q <= beatLast_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = HDR;
        end else if (fin) begin
            state_d = IDLE;
        end else if (consume && (state_q == HDR)) begin
            state_d = BODY;
        end
    end

    // Next values of the buffer and of the registered beat outputs.
    always_comb begin
        len_d      = len_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rdyBeat_d  = rdyBeat_q;
        beatV_d    = beatV_q;
        beatLast_d = beatLast_q;
        if (accept) begin
            len_d      = lenClamped;
            data_d     = msg_data;
            cnt_d      = '0;
            rdyBeat_d  = 1'b1;
            beatV_d    = width'(vsim_make_header(msg_id, hdrWords));
            beatLast_d = (lenClamped == '0);
        end else if (fin) begin
            rdyBeat_d  = 1'b0;
            beatLast_d = 1'b0;
        end else if (consume && (state_q == HDR)) begin
            cnt_d      = '0;
            beatV_d    = data_q[width-1:0];
            beatLast_d = (len_q == LEN_W'(1));
        end else if (consume && (state_q == BODY)) begin
            cnt_d      = cntNext;
            beatV_d    = data_q[selBase +: width];
            beatLast_d = bodyLast;
        end
    end

    assign RDY_beat  = rdyBeat_q;
    assign beat_v    = beatV_q;
    assign beat_last = beatLast_q;

    // Misuse of either handshake is ignored by the logic; flag it in simulation.
    assert property (@(posedge CLK) disable iff (nRST) EN_beat |-> RDY_beat);
    assert property (@(posedge CLK) disable iff (nRST) EN_msg |-> RDY_msg);
    assert property (@(posedge CLK) disable iff (nRST)
                     (EN_msg && RDY_msg) |-> (msg_len <= LEN_W'(MAX_WORDS)));

endmodule

// File: tb/tb_vsim_msg_serializer.sv
// ---------------------------------------------------------------------------
// tb_vsim_msg_serializer
// Scoreboard bench for vsim_msg_serializer. applyStimulus offers a message
// and queues the beats it should produce (with the cycle each should leave
// on, where timing matters); a monitor pops and compares every consumed beat.
// ---------------------------------------------------------------------------
module tb_vsim_msg_serializer;

    localparam int WIDTH = 32;
    localparam int MAXW  = 4;
    localparam int LENW  = 3;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          cyc;
    } beat_t;

    logic                  CLK = 1'b0;
    logic                  nRST = 1'b1;
    logic                  EN_msg = 1'b0;
    logic                  RDY_msg;
    logic [15:0]           msgId = '0;
    logic [LENW-1:0]       msgLen = '0;
    logic [MAXW*WIDTH-1:0] msgData = '0;
    logic                  RDY_beat;
    logic                  EN_beat;
    logic [WIDTH-1:0]      beatV;
    logic                  beatLast;
    logic                  sinkEnable = 1'b0;

    int    cyc = 0;
    int    checkCount = 0;
    int    failCount = 0;
    int    beatsSeen = 0;
    beat_t expQ[$];

    // The send stage takes a beat whenever one is offered, unless stalled.
    assign EN_beat = RDY_beat && sinkEnable;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    vsim_msg_serializer #(
        .width(WIDTH),
        .MAX_WORDS(MAXW),
        .LEN_W(LENW)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .EN_msg(EN_msg),
        .RDY_msg(RDY_msg),
        .msg_id(msgId),
        .msg_len(msgLen),
        .msg_data(msgData),
        .RDY_beat(RDY_beat),
        .EN_beat(EN_beat),
        .beat_v(beatV),
        .beat_last(beatLast)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offer one message when RDY_msg allows and queue its expected beats.
    // timed=1 pins each beat to the cycle it must be consumed in.
    task automatic applyStimulus(input logic [15:0] id, input int len,
                                 input logic [MAXW*WIDTH-1:0] data,
                                 input logic [31:0] expHdr, input bit timed,
                                 output int accCyc);
        int    waited = 0;
        beat_t e;
        accCyc = -1;
        @(negedge CLK);
        msgId   = id;
        msgLen  = LENW'(len);
        msgData = data;
        #1;
        while (!RDY_msg && waited < 50) begin
            @(negedge CLK);
            #1;
            waited++;
        end
        if (!RDY_msg) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL accept_timeout: RDY_msg got 0, expected 1");
            return;
        end
        EN_msg = 1'b1;
        accCyc = cyc;
        e.data = expHdr;
        e.last = (len == 0);
        e.cyc  = timed ? cyc + 1 : -1;
        expQ.push_back(e);
        for (int k = 0; k < len; k++) begin
            e.data = 32'(data >> (32 * k));
            e.last = (k == len - 1);
            e.cyc  = timed ? cyc + 2 + k : -1;
            expQ.push_back(e);
        end
        @(posedge CLK);
        #1;
        EN_msg = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int waited = 0;
        while ((expQ.size() != 0 || RDY_beat) && waited < 100) begin
            @(negedge CLK);
            #3;
            waited++;
        end
        checkOutput({name, "_pending_beats"}, 32'(expQ.size()), 32'd0);
        checkOutput({name, "_rdy_beat_idle"}, 32'(RDY_beat), 32'd0);
    endtask

    // Monitor: every beat the sink takes must match the head of the queue.
    initial begin
        beat_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (!nRST && RDY_beat && EN_beat) begin
                beatsSeen++;
                if (expQ.size() == 0) begin
                    checkCount++;
                    failCount++;
                    $display("[TB] FAIL unexpected_beat: got %h last=%0b, expected no beat",
                             beatV, beatLast);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("beat_data", beatV, e.data);
                    checkOutput("beat_last", 32'(beatLast), 32'(e.last));
                    if (e.cyc >= 0) checkOutput("beat_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc1;
        int acc2;
        int base;
        int waited;

        // Reset held with an enqueue strobe: nothing may be accepted.
        nRST       = 1'b1;
        EN_msg     = 1'b1;
        sinkEnable = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            #1;
            checkOutput("reset_rdy_msg", 32'(RDY_msg), 32'd0);
            checkOutput("reset_rdy_beat", 32'(RDY_beat), 32'd0);
            checkOutput("reset_beat_v", beatV, 32'd0);
            checkOutput("reset_beat_last", 32'(beatLast), 32'd0);
        end
        @(negedge CLK);
        nRST   = 1'b0;
        EN_msg = 1'b0;
        @(negedge CLK);
        #1;
        checkOutput("post_reset_rdy_beat", 32'(RDY_beat), 32'd0);
        checkOutput("post_reset_rdy_msg", 32'(RDY_msg), 32'd1);

        $display("[TB] zero-payload message");
        applyStimulus(16'h0005, 0, '0, 32'h0005_0001, 1'b1, acc1);
        waitDrain("zero_payload");

        $display("[TB] full message");
        applyStimulus(16'h0012, 3, {32'h0, 32'hCCCC_00C2, 32'hBBBB_00B1, 32'hAAAA_00A0},
                      32'h0012_0004, 1'b1, acc1);
        waitDrain("full_msg");

        $display("[TB] backpressure");
        @(negedge CLK);
        sinkEnable = 1'b0;
        applyStimulus(16'h0012, 3, {32'h0, 32'hCCCC_00C2, 32'hBBBB_00B1, 32'hAAAA_00A0},
                      32'h0012_0004, 1'b0, acc1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_rdy_beat", 32'(RDY_beat), 32'd1);
            checkOutput("stall_hdr_v", beatV, 32'h0012_0004);
            checkOutput("stall_hdr_last", 32'(beatLast), 32'd0);
            @(negedge CLK);
            #1;
        end
        @(negedge CLK);
        sinkEnable = 1'b1;
        waitDrain("backpressure");

        $display("[TB] back-to-back messages");
        applyStimulus(16'h0012, 3, {32'h0, 32'hCCCC_00C2, 32'hBBBB_00B1, 32'hAAAA_00A0},
                      32'h0012_0004, 1'b1, acc1);
        applyStimulus(16'h0007, 1, {96'h0, 32'h0000_dead}, 32'h0007_0002, 1'b1, acc2);
        checkOutput("b2b_accept_cycle", 32'(acc2), 32'(acc1 + 4));
        waitDrain("back_to_back");

        $display("[TB] reset mid-message");
        base = beatsSeen;
        applyStimulus(16'h0042, 4, {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000},
                      32'h0042_0005, 1'b1, acc1);
        waited = 0;
        while (beatsSeen < base + 1 && waited < 20) begin
            @(negedge CLK);
            #3;
            waited++;
        end
        checkOutput("midrst_hdr_consumed", 32'(beatsSeen - base), 32'd1);
        @(negedge CLK);
        nRST       = 1'b1;
        sinkEnable = 1'b0;
        #1;
        checkOutput("midrst_rdy_msg", 32'(RDY_msg), 32'd0);
        @(negedge CLK);
        #1;
        checkOutput("midrst_rdy_beat", 32'(RDY_beat), 32'd0);
        checkOutput("midrst_beat_v", beatV, 32'd0);
        checkOutput("midrst_beat_last", 32'(beatLast), 32'd0);
        expQ.delete();
        @(negedge CLK);
        nRST       = 1'b0;
        sinkEnable = 1'b1;
        base = beatsSeen;
        applyStimulus(16'h0001, 0, '0, 32'h0001_0001, 1'b1, acc1);
        waitDrain("after_midrst");
        repeat (5) @(negedge CLK);
        #3;
        checkOutput("after_midrst_beat_count", 32'(beatsSeen - base), 32'd1);
        checkOutput("after_midrst_rdy_beat", 32'(RDY_beat), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
